// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: maps the tracker drive mode to left/right wheel PWM enables.
// Duty changes are slew-limited once per PWM period (soft start), and any change
// of wheel direction class (forward / pivot-left / pivot-right / reverse) forces
// a number of full zero-duty periods so the H-bridge never reverses under load.
module motor_pwm_ramp #(
    parameter int PWM_BITS     = 10,
    parameter int PRESCALE     = 98,
    parameter int DUTY_FAST    = 720,
    parameter int DUTY_SLOW    = 560,
    parameter int DUTY_PIVOT   = 640,
    parameter int RAMP_STEP    = 64,
    parameter int DEAD_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          mode,
    input  logic                stop,
    output logic [1:0]          pwm,
    output logic [PWM_BITS-1:0] duty_l,
    output logic [PWM_BITS-1:0] duty_r,
    output logic                period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DC_W = $clog2(DEAD_PERIODS + 1);

    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] D_FAST   = PWM_BITS'(DUTY_FAST);
    localparam logic [PWM_BITS-1:0] D_SLOW   = PWM_BITS'(DUTY_SLOW);
    localparam logic [PWM_BITS-1:0] D_PIVOT  = PWM_BITS'(DUTY_PIVOT);
    localparam logic [PWM_BITS-1:0] D_ZERO   = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] D_STEP   = PWM_BITS'(RAMP_STEP);
    localparam logic [DC_W-1:0]     DEAD_END = DC_W'(DEAD_PERIODS);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DEAD = 1'b1} state_t;
    typedef enum logic [1:0] {CL_FWD = 2'd0, CL_PIVL = 2'd1, CL_PIVR = 2'd2, CL_REV = 2'd3} class_t;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    state_t              state_q, state_d;
    class_t              class_q, class_d;
    logic [DC_W-1:0]     dead_q, dead_d;
    logic [PWM_BITS-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic [1:0]          pwm_q, pwm_d;
    logic                period_start_q, period_start_d;

    logic                tick_s, wrap_s, class_chg_s;
    logic [PWM_BITS-1:0] tgt_l_s, tgt_r_s;
    class_t              mode_cls_s;
    logic [DC_W-1:0]     dead_inc_s;

    // Move a duty toward its target by at most one ramp step, never overshooting.
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            ramp_toward = (diff > D_STEP) ? (cur + D_STEP) : tgt;
        end else begin
            diff = cur - tgt;
            ramp_toward = (diff > D_STEP) ? (cur - D_STEP) : tgt;
        end
    endfunction

    assign tick_s      = (presc_q == PS_LAST);
    assign wrap_s      = tick_s && (cnt_q == CNT_LAST);
    assign class_chg_s = (mode_cls_s != class_q);
    assign dead_inc_s  = dead_q + DC_W'(1);

    // Decode drive mode into wheel duty targets and direction class.
    always_comb begin
        tgt_l_s    = D_ZERO;
        tgt_r_s    = D_ZERO;
        mode_cls_s = class_q;
        case (mode)
            3'd0: begin tgt_l_s = D_SLOW;  tgt_r_s = D_FAST;  mode_cls_s = CL_FWD;  end
            3'd1: begin tgt_l_s = D_FAST;  tgt_r_s = D_SLOW;  mode_cls_s = CL_FWD;  end
            3'd2: begin tgt_l_s = D_FAST;  tgt_r_s = D_FAST;  mode_cls_s = CL_FWD;  end
            3'd3: begin tgt_l_s = D_PIVOT; tgt_r_s = D_PIVOT; mode_cls_s = CL_PIVL; end
            3'd4: begin tgt_l_s = D_PIVOT; tgt_r_s = D_PIVOT; mode_cls_s = CL_PIVR; end
            3'd5: begin tgt_l_s = D_SLOW;  tgt_r_s = D_SLOW;  mode_cls_s = CL_REV;  end
            default: begin tgt_l_s = D_ZERO; tgt_r_s = D_ZERO; mode_cls_s = class_q; end
        endcase
    end

    // Next-state logic: timebase, RUN/DEAD sequencing and duty ramping.
    always_comb begin
        presc_d        = tick_s ? {PS_W{1'b0}} : (presc_q + PS_W'(1));
        cnt_d          = tick_s ? (cnt_q + PWM_BITS'(1)) : cnt_q;
        state_d        = state_q;
        class_d        = class_q;
        dead_d         = dead_q;
        duty_l_d       = duty_l_q;
        duty_r_d       = duty_r_q;
        pwm_d          = {(cnt_q < duty_l_q), (cnt_q < duty_r_q)};
        period_start_d = wrap_s;

        if (class_chg_s) begin
            // Direction class change wins over a coincident wrap and restarts dead time.
            state_d  = ST_DEAD;
            class_d  = mode_cls_s;
            dead_d   = {DC_W{1'b0}};
            duty_l_d = D_ZERO;
            duty_r_d = D_ZERO;
        end else if (state_q == ST_DEAD) begin
            duty_l_d = D_ZERO;
            duty_r_d = D_ZERO;
            if (wrap_s) begin
                dead_d = dead_inc_s;
                if (dead_inc_s == DEAD_END) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DEAD;
                end
            end else begin
                dead_d = dead_q;
            end
        end else if (stop) begin
            duty_l_d = D_ZERO;
            duty_r_d = D_ZERO;
        end else if (wrap_s) begin
            duty_l_d = ramp_toward(duty_l_q, tgt_l_s);
            duty_r_d = ramp_toward(duty_r_q, tgt_r_s);
        end else begin
            duty_l_d = duty_l_q;
            duty_r_d = duty_r_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q        <= {PS_W{1'b0}};
            cnt_q          <= {PWM_BITS{1'b0}};
            state_q        <= ST_RUN;
            class_q        <= CL_FWD;
            dead_q         <= {DC_W{1'b0}};
            duty_l_q       <= D_ZERO;
            duty_r_q       <= D_ZERO;
            pwm_q          <= 2'b00;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            class_q        <= class_d;
            dead_q         <= dead_d;
            duty_l_q       <= duty_l_d;
            duty_r_q       <= duty_r_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign duty_l       = duty_l_q;
    assign duty_r       = duty_r_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Testbench for motor_pwm_ramp with a small configuration (16-tick period, 2 clk per tick).
// Expected duty pairs are queued when stimulus is applied and compared at each period start.
module tb_motor_pwm_ramp;

    localparam int PWM_BITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          mode;
    logic                stop;
    logic [1:0]          pwm;
    logic [PWM_BITS-1:0] duty_l;
    logic [PWM_BITS-1:0] duty_r;
    logic                period_start;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    motor_pwm_ramp #(
        .PWM_BITS(4), .PRESCALE(2), .DUTY_FAST(12), .DUTY_SLOW(8),
        .DUTY_PIVOT(10), .RAMP_STEP(4), .DEAD_PERIODS(2)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .stop(stop), .pwm(pwm),
        .duty_l(duty_l), .duty_r(duty_r), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int l, input int r);
        logic [3:0] lv;
        logic [3:0] rv;
        lv = 4'(l);
        rv = 4'(r);
        exp_q.push_back({lv, rv});
    endtask

    // Wait (bounded) until every queued expectation has been consumed.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq({tag, "_drain_left"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Scoreboard: at each period start compare applied duties with the oldest expectation.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && period_start && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("wrap_duty_l", duty_l, e[7:4]);
            check_eq("wrap_duty_r", duty_r, e[3:0]);
        end
    end

    initial begin
        int hl;
        int hr;
        int n;
        rst  = 1'b1;
        mode = 3'd2;
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pwm", pwm, 2'b00);
        check_eq("rst_duty_l", duty_l, 0);
        check_eq("rst_duty_r", duty_r, 0);
        check_eq("rst_pstart", period_start, 0);

        // 1: soft start straight
        push_exp(4, 4); push_exp(8, 8); push_exp(12, 12); push_exp(12, 12);
        rst = 1'b0;
        drain("t1");
        hl = 0; hr = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            hl += int'(pwm[1]);
            hr += int'(pwm[0]);
        end
        check_eq("t1_pwm_l_high", hl, 24);
        check_eq("t1_pwm_r_high", hr, 24);

        // 2: gentle left, same class, no dead time
        mode = 3'd0;
        push_exp(8, 12); push_exp(8, 12);
        drain("t2");
        mode = 3'd2;
        push_exp(12, 12);
        drain("t2b");

        // 3: pivot left from straight -> dead time then ramp to 10
        @(negedge clk);
        mode = 3'd3;
        @(posedge clk); #1;
        check_eq("t3_imm_duty_l", duty_l, 0);
        check_eq("t3_imm_duty_r", duty_r, 0);
        push_exp(0, 0); push_exp(0, 0); push_exp(4, 4); push_exp(8, 8);
        push_exp(10, 10); push_exp(10, 10);
        drain("t3");

        // 4: enter dead (pivot right), then reverse restarts dead count
        mode = 3'd4;
        push_exp(0, 0);
        drain("t4a");
        mode = 3'd5;
        push_exp(0, 0); push_exp(0, 0); push_exp(4, 4); push_exp(8, 8); push_exp(8, 8);
        drain("t4b");

        // 5: back to straight, then stop mid-period and release
        mode = 3'd2;
        push_exp(0, 0); push_exp(0, 0); push_exp(4, 4); push_exp(8, 8);
        push_exp(12, 12); push_exp(12, 12);
        drain("t5a");
        repeat (8) @(negedge clk);
        stop = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_eq("t5_stop_pwm", pwm, 2'b00);
        check_eq("t5_stop_duty_l", duty_l, 0);
        push_exp(0, 0);
        drain("t5b");
        stop = 1'b0;
        push_exp(4, 4); push_exp(8, 8); push_exp(12, 12);
        drain("t5c");

        // 6: asynchronous reset mid-period while both wheels are driven
        repeat (4) @(negedge clk);
        check_eq("t6_pre_pwm", pwm, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_pwm", pwm, 2'b00);
        check_eq("t6_rst_duty_l", duty_l, 0);
        check_eq("t6_rst_duty_r", duty_r, 0);
        check_eq("t6_rst_pstart", period_start, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (period_start) break;
        end
        check_eq("t6_first_pstart_clk", n, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
